// File: rtl/trap_ctrl_if.sv
// Commit/CSR/fetch signal bundle for the trap controller.
// The slave modport is the trap controller's view; the master modport is
// the surrounding pipeline (commit stage, CSR file, fetch unit).
interface trap_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int HART_ID_W = 1
);
  logic [HART_ID_W-1:0] hart_id;
  logic                 instr_valid;
  logic [XLEN-1:0]      instr_pc;
  logic                 exc_illegal;
  logic                 exc_ecall;
  logic                 is_mret;
  logic                 ext_irq;
  logic [XLEN-1:0]      mstatus_i;
  logic [XLEN-1:0]      mie_i;
  logic [XLEN-1:0]      mtvec_i;
  logic [XLEN-1:0]      mepc_i;
  logic                 trap_set;
  logic                 trap_mret;
  logic [HART_ID_W-1:0] trap_hart_id;
  logic [XLEN-1:0]      trap_mepc;
  logic [XLEN-1:0]      trap_mcause;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 redirect_ready;
  logic                 commit_stall;

  modport master (
    output hart_id, instr_valid, instr_pc, exc_illegal, exc_ecall, is_mret,
           ext_irq, mstatus_i, mie_i, mtvec_i, mepc_i, redirect_ready,
    input  trap_set, trap_mret, trap_hart_id, trap_mepc, trap_mcause,
           redirect_valid, redirect_pc, commit_stall
  );

  modport slave (
    input  hart_id, instr_valid, instr_pc, exc_illegal, exc_ecall, is_mret,
           ext_irq, mstatus_i, mie_i, mtvec_i, mepc_i, redirect_ready,
    output trap_set, trap_mret, trap_hart_id, trap_mepc, trap_mcause,
           redirect_valid, redirect_pc, commit_stall
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: detects interrupts, exceptions and MRET at
// commit, pulses the CSR file once, then holds a fetch redirect until the
// fetch unit accepts it. The commit stage is stalled for the whole sequence.
module trap_ctrl #(
  parameter int XLEN      = 32,
  parameter int HART_NUM  = 2,
  parameter int HART_ID_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PULSE, REDIRECT} state_e;

  localparam logic [XLEN-1:0] CauseIrq     = {1'b1, (XLEN-1)'(11)};
  localparam logic [XLEN-1:0] CauseIllegal = XLEN'(2);
  localparam logic [XLEN-1:0] CauseEcall   = XLEN'(11);

  state_e               state_q;
  logic                 irq_meta_q;
  logic                 irq_s_q;
  logic                 trap_set_q;
  logic                 trap_mret_q;
  logic                 redirect_valid_q;
  logic [HART_ID_W-1:0] hart_q;
  logic [XLEN-1:0]      mepc_q;
  logic [XLEN-1:0]      mcause_q;
  logic [XLEN-1:0]      redirect_pc_q;

  logic                 irq_take;
  logic                 event_det;
  logic [XLEN-1:0]      trap_vector;
  logic                 unused_bits;

  // Two-flop synchronizer for the asynchronous external interrupt level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta_q <= 1'b0;
      irq_s_q    <= 1'b0;
    end else begin
      irq_meta_q <= bus.ext_irq;
      irq_s_q    <= irq_meta_q;
    end
  end

  assign irq_take    = irq_s_q & bus.mstatus_i[3] & bus.mie_i[11] & bus.instr_valid;
  assign event_det   = (state_q == IDLE) &
                       (irq_take | (bus.instr_valid &
                                    (bus.exc_illegal | bus.exc_ecall | bus.is_mret)));
  assign trap_vector = {bus.mtvec_i[XLEN-1:2], 2'b00};

  // Only MIE/MEIE and the aligned vector base matter; the rest is sunk here
  assign unused_bits = ^{bus.mstatus_i[XLEN-1:4], bus.mstatus_i[2:0],
                         bus.mie_i[XLEN-1:12], bus.mie_i[10:0],
                         bus.mtvec_i[1:0], 32'(HART_NUM)};

  // Stall commit while a trap/MRET is in flight, including the detection cycle
  assign bus.commit_stall = (state_q != IDLE) | event_det;

  // Trap FSM: capture the winning event, pulse the CSR file, then hold redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      trap_set_q       <= 1'b0;
      trap_mret_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      hart_q           <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (event_det) begin
            state_q <= PULSE;
            hart_q  <= bus.hart_id;
            if (irq_take) begin
              trap_set_q    <= 1'b1;
              mepc_q        <= bus.instr_pc;
              mcause_q      <= CauseIrq;
              redirect_pc_q <= trap_vector;
            end else if (bus.exc_illegal) begin
              trap_set_q    <= 1'b1;
              mepc_q        <= bus.instr_pc;
              mcause_q      <= CauseIllegal;
              redirect_pc_q <= trap_vector;
            end else if (bus.exc_ecall) begin
              trap_set_q    <= 1'b1;
              mepc_q        <= bus.instr_pc;
              mcause_q      <= CauseEcall;
              redirect_pc_q <= trap_vector;
            end else begin
              trap_mret_q   <= 1'b1;
              redirect_pc_q <= bus.mepc_i;
            end
          end
        end
        PULSE: begin
          trap_set_q       <= 1'b0;
          trap_mret_q      <= 1'b0;
          redirect_valid_q <= 1'b1;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.trap_set       = trap_set_q;
  assign bus.trap_mret      = trap_mret_q;
  assign bus.trap_hart_id   = hart_q;
  assign bus.trap_mepc      = mepc_q;
  assign bus.trap_mcause    = mcause_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR pulses and
// redirect targets; a negedge monitor pops and compares them as they appear.
module tb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int HW   = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN), .HART_ID_W(HW)) bus ();

  trap_ctrl #(.XLEN(XLEN), .HART_NUM(2), .HART_ID_W(HW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          isMret;
    logic [HW-1:0] hart;
    logic [31:0]   mepc;
    logic [31:0]   mcause;
    logic [31:0]   rpc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  logic [31:0] pendRpc;
  logic        pendValid = 1'b0;
  logic        prevRv = 1'b0;
  logic [31:0] lastMepc = '0;
  logic [31:0] lastMcause = '0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [HW-1:0] h, input logic [31:0] pc,
                               input logic ill, input logic ec, input logic mr);
    bus.instr_valid = v;
    bus.hart_id     = h;
    bus.instr_pc    = pc;
    bus.exc_illegal = ill;
    bus.exc_ecall   = ec;
    bus.is_mret     = mr;
  endtask

  function automatic exp_t mkExp(input logic isM, input logic [HW-1:0] h, input logic [31:0] mepc,
                                 input logic [31:0] mcause, input logic [31:0] rpc);
    exp_t e;
    e.isMret = isM;
    e.hart   = h;
    e.mepc   = mepc;
    e.mcause = mcause;
    e.rpc    = rpc;
    return e;
  endfunction

  task automatic pushExp(input exp_t e);
    expQ.push_back(e);
    lastMepc   = e.mepc;
    lastMcause = e.mcause;
  endtask

  // Caller has applied the event inputs just after a rising edge.
  task automatic runEvent(input string tag, input exp_t e, input int hold);
    #1;
    checkOutput({tag, "_stall_detect"}, 32'(bus.commit_stall), 32'd1);
    pushExp(e);
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_stall_pulse"}, 32'(bus.commit_stall), 32'd1);
    tick(1);
    checkOutput({tag, "_rv_set"}, 32'(bus.redirect_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.redirect_ready = 1'b0;
      tick(1);
      checkOutput({tag, "_rv_hold"}, 32'(bus.redirect_valid), 32'd1);
      checkOutput({tag, "_rpc_hold"}, bus.redirect_pc, e.rpc);
      checkOutput({tag, "_stall_hold"}, 32'(bus.commit_stall), 32'd1);
    end
    bus.redirect_ready = 1'b1;
    tick(1);
    bus.redirect_ready = 1'b0;
    checkOutput({tag, "_rv_done"}, 32'(bus.redirect_valid), 32'd0);
    checkOutput({tag, "_stall_done"}, 32'(bus.commit_stall), 32'd0);
  endtask

  // Monitor: compare each CSR pulse and each new redirect against the queue
  always @(negedge clk) begin
    if (rst) begin
      prevRv    = 1'b0;
      pendValid = 1'b0;
    end else begin
      if (bus.trap_set || bus.trap_mret) begin
        checkOutput("pulse_exclusive", 32'(bus.trap_set & bus.trap_mret), 32'd0);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_pulse: got set=%0b mret=%0b, want none",
                   bus.trap_set, bus.trap_mret);
        end else begin
          monE = expQ.pop_front();
          checkOutput("trap_set", 32'(bus.trap_set), 32'(!monE.isMret));
          checkOutput("trap_mret", 32'(bus.trap_mret), 32'(monE.isMret));
          checkOutput("trap_hart_id", 32'(bus.trap_hart_id), 32'(monE.hart));
          checkOutput("trap_mepc", bus.trap_mepc, monE.mepc);
          checkOutput("trap_mcause", bus.trap_mcause, monE.mcause);
          pendRpc   = monE.rpc;
          pendValid = 1'b1;
        end
      end
      if (bus.redirect_valid && !prevRv) begin
        if (!pendValid) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_redirect: got pc=0x%0h, want no redirect", bus.redirect_pc);
        end else begin
          checkOutput("redirect_pc", bus.redirect_pc, pendRpc);
        end
        pendValid = 1'b0;
      end
      prevRv = bus.redirect_valid;
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.ext_irq        = 1'b0;
    bus.mstatus_i      = '0;
    bus.mie_i          = '0;
    bus.mtvec_i        = '0;
    bus.mepc_i         = '0;
    bus.redirect_ready = 1'b0;
    tick(3);
    checkOutput("rst_trap_set", 32'(bus.trap_set), 32'd0);
    checkOutput("rst_trap_mret", 32'(bus.trap_mret), 32'd0);
    checkOutput("rst_rv", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rst_hart", 32'(bus.trap_hart_id), 32'd0);
    checkOutput("rst_mepc", bus.trap_mepc, 32'd0);
    checkOutput("rst_mcause", bus.trap_mcause, 32'd0);
    checkOutput("rst_rpc", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    tick(1);

    // Plain instruction: no stall, nothing happens
    applyStimulus(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("plain_stall", 32'(bus.commit_stall), 32'd0);
    tick(1);
    checkOutput("plain_set", 32'(bus.trap_set), 32'd0);
    checkOutput("plain_rv", 32'(bus.redirect_valid), 32'd0);

    // ECALL from hart 1 with a misaligned-mode mtvec, long redirect hold
    bus.mtvec_i = 32'h203;
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    runEvent("ecall", mkExp(1'b0, 1'b1, 32'h100, 32'hB, 32'h200), 5);

    // Illegal instruction, immediate ready
    bus.mtvec_i = 32'h1000;
    applyStimulus(1'b1, 1'b0, 32'h444, 1'b1, 1'b0, 1'b0);
    runEvent("illegal", mkExp(1'b0, 1'b0, 32'h444, 32'h2, 32'h1000), 0);

    // Interrupt: two cycles of synchronizer latency before the take
    bus.mstatus_i = 32'h8;
    bus.mie_i     = 32'h800;
    bus.mtvec_i   = 32'h2000;
    applyStimulus(1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0);
    bus.ext_irq = 1'b1;
    #1 checkOutput("irq_lat0", 32'(bus.commit_stall), 32'd0);
    tick(1);
    checkOutput("irq_lat1", 32'(bus.commit_stall), 32'd0);
    tick(1);
    bus.ext_irq = 1'b0;
    runEvent("irq", mkExp(1'b0, 1'b0, 32'h500, 32'h8000000B, 32'h2000), 1);

    // Interrupt masked by MEIE: never taken
    bus.mie_i   = 32'h0;
    bus.ext_irq = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h600, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("irq_masked_stall", 32'(bus.commit_stall), 32'd0);
      checkOutput("irq_masked_set", 32'(bus.trap_set), 32'd0);
    end

    // Priority: synchronized irq beats illegal and MRET in the same cycle
    bus.mie_i  = 32'h800;
    bus.mepc_i = 32'h9999;
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 1'b1);
    bus.ext_irq = 1'b0;
    runEvent("prio_irq", mkExp(1'b0, 1'b1, 32'h700, 32'h8000000B, 32'h2000), 1);

    // Priority: illegal beats ecall
    bus.mie_i   = 32'h0;
    bus.mtvec_i = 32'h3001;
    applyStimulus(1'b1, 1'b0, 32'h800, 1'b1, 1'b1, 1'b0);
    runEvent("prio_ill", mkExp(1'b0, 1'b0, 32'h800, 32'h2, 32'h3000), 0);

    // MRET: mepc/mcause outputs keep the previous trap's values
    bus.mepc_i = 32'h340;
    applyStimulus(1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 1'b1);
    runEvent("mret", mkExp(1'b1, 1'b1, lastMepc, lastMcause, 32'h340), 2);

    // Reset during REDIRECT aborts with no later pulse
    bus.mtvec_i = 32'h4000;
    applyStimulus(1'b1, 1'b0, 32'hA00, 1'b0, 1'b1, 1'b0);
    #1 pushExp(mkExp(1'b0, 1'b0, 32'hA00, 32'hB, 32'h4000));
    tick(1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("abort_rv_before", 32'(bus.redirect_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_rv", 32'(bus.redirect_valid), 32'd0);
    checkOutput("abort_rpc", bus.redirect_pc, 32'd0);
    checkOutput("abort_mepc", bus.trap_mepc, 32'd0);
    checkOutput("abort_stall", 32'(bus.commit_stall), 32'd0);
    tick(2);
    rst = 1'b0;
    lastMepc   = '0;
    lastMcause = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("post_rst_set", 32'(bus.trap_set), 32'd0);
      checkOutput("post_rst_rv", 32'(bus.redirect_valid), 32'd0);
    end

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
